iobus_iot_sequencer: RTL and testbench

Master-side controller for the PDP-6 IO bus.
- Accepts one IOT command at a time (DATAO, CONO, DATAI, CONI) over a valid/ready handshake.
- Sequences the bus strobes with programmable widths: clear/set pulses for writes, datai/status strobes for reads.
- Generates power-on and IO-reset pulses and registers a priority encoding of the PI request lines.
- Drives the master inputs of the IO bus interconnect and consumes its read-back data and PI requests.

---
 rtl/iobus_iot_sequencer.sv | 150 +++++++++++++++
 tb/tb_iobus_iot_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_iot_sequencer.sv
// PDP-6 IO bus master: sequences one IOT (DATAO/CONO/DATAI/CONI) at a time with
// programmable strobe widths, plus power-on / IO-reset pulses and PI priority encoding.
module iobus_iot_sequencer #(
    parameter int CLR_CYC = 4,
    parameter int GAP_CYC = 2,
    parameter int SET_CYC = 4,
    parameter int RD_CYC  = 4,
    parameter int RST_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:9]  cmd_dev,
    input  logic [0:35] cmd_data,
    output logic        rsp_valid,
    output logic [0:35] rsp_data,
    input  logic        io_reset_req,
    output logic        iob_poweron,
    output logic        iob_reset,
    output logic        datao_clear,
    output logic        datao_set,
    output logic        cono_clear,
    output logic        cono_set,
    output logic        iob_fm_datai,
    output logic        iob_fm_status,
    output logic [3:9]  ios,
    output logic [0:35] iob_write,
    input  logic [0:35] iob_read,
    input  logic [1:7]  pi_req,
    output logic [2:0]  pi_level,
    output logic        pi_any
);

    localparam int MAX_A   = (CLR_CYC > SET_CYC) ? CLR_CYC : SET_CYC;
    localparam int MAX_B   = (RD_CYC > RST_CYC) ? RD_CYC : RST_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > GAP_CYC) ? MAX_C : GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_CLR, S_GAP1, S_SET, S_RD, S_TAIL, S_DONE
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d, lim;
    logic          cnt_end, accept, rst_done, rst_pend, busy;
    logic [1:0]    op_q;
    logic [3:9]    dev_q;
    logic [0:35]   data_q, rd_buf;
    logic [2:0]    pi_enc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RST;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CW'(1);
        cmd_ready = (state == S_IDLE) && !rst_pend && !io_reset_req;
        case (state)
            S_RST:         lim = CW'(RST_CYC - 1);
            S_CLR:         lim = CW'(CLR_CYC - 1);
            S_GAP1, S_TAIL: lim = CW'(GAP_CYC - 1);
            S_SET:         lim = CW'(SET_CYC - 1);
            S_RD:          lim = CW'(RD_CYC - 1);
            default:       lim = '0;
        endcase
        cnt_end = (cnt == lim);
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (rst_pend)
                    state_d = S_RST;
                else if (cmd_valid && cmd_ready)
                    state_d = cmd_op[1] ? S_RD : S_CLR;
            end
            // Power-on edge is spent raising iob_poweron; the reset pulse counts after it.
            S_RST: begin
                if (!iob_poweron) cnt_d = '0;
                else if (cnt_end) begin state_d = S_IDLE; cnt_d = '0; end
            end
            S_CLR:  if (cnt_end) begin state_d = S_GAP1; cnt_d = '0; end
            S_GAP1: if (cnt_end) begin state_d = S_SET;  cnt_d = '0; end
            S_SET:  if (cnt_end) begin state_d = S_TAIL; cnt_d = '0; end
            S_RD:   if (cnt_end) begin state_d = S_TAIL; cnt_d = '0; end
            S_TAIL: if (cnt_end) begin state_d = S_DONE; cnt_d = '0; end
            default: begin state_d = S_IDLE; cnt_d = '0; end
        endcase
    end

    assign accept   = cmd_valid && cmd_ready;
    assign rst_done = (state == S_RST) && iob_poweron && cnt_end;
    assign busy     = (state != S_IDLE) && (state != S_RST);

    assign iob_reset     = (state == S_RST) && iob_poweron;
    assign rsp_valid     = (state == S_DONE);
    assign datao_clear   = (state == S_CLR) && (op_q == 2'd0);
    assign cono_clear    = (state == S_CLR) && (op_q == 2'd1);
    assign datao_set     = (state == S_SET) && (op_q == 2'd0);
    assign cono_set      = (state == S_SET) && (op_q == 2'd1);
    assign iob_fm_datai  = (state == S_RD)  && (op_q == 2'd2);
    assign iob_fm_status = (state == S_RD)  && (op_q == 2'd3);
    assign ios           = busy ? dev_q : '0;
    assign iob_write     = (busy && !op_q[1]) ? data_q : '0;

    always_comb begin
        pi_enc = '0;
        for (int i = 7; i >= 1; i--)
            if (pi_req[i]) pi_enc = 3'(i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iob_poweron <= 1'b0;
            rst_pend    <= 1'b1;
            op_q        <= '0;
            dev_q       <= '0;
            data_q      <= '0;
            rd_buf      <= '0;
            rsp_data    <= '0;
            pi_level    <= '0;
            pi_any      <= 1'b0;
        end else begin
            iob_poweron <= 1'b1;
            // A request arriving on the last reset cycle re-arms the pulse.
            rst_pend    <= io_reset_req || (rst_pend && !rst_done);
            if (accept) begin
                op_q   <= cmd_op;
                dev_q  <= cmd_dev;
                data_q <= cmd_data;
            end
            if (state == S_RD && cnt_end)
                rd_buf <= iob_read;
            // rsp_data only changes on entry to DONE so it holds between completions.
            if (state == S_TAIL && cnt_end)
                rsp_data <= op_q[1] ? rd_buf : '0;
            pi_level <= pi_enc;
            pi_any   <= |pi_req;
        end
    end

endmodule

// File: tb/tb_iobus_iot_sequencer.sv
// Scoreboard bench for iobus_iot_sequencer: random IOTs checked against window
// arithmetic for strobes/bus and a response queue popped on rsp_valid.
module tb_iobus_iot_sequencer;

    localparam int CLR_CYC = 4;
    localparam int GAP_CYC = 2;
    localparam int SET_CYC = 4;
    localparam int RD_CYC  = 4;
    localparam int RST_CYC = 8;
    localparam int LEN_W   = CLR_CYC + GAP_CYC + SET_CYC + GAP_CYC + 1;
    localparam int LEN_R   = RD_CYC + GAP_CYC + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [3:9]  cmd_dev = '0;
    logic [0:35] cmd_data = '0;
    logic        rsp_valid;
    logic [0:35] rsp_data;
    logic        io_reset_req = 1'b0;
    logic        iob_poweron, iob_reset;
    logic        datao_clear, datao_set, cono_clear, cono_set, iob_fm_datai, iob_fm_status;
    logic [3:9]  ios;
    logic [0:35] iob_write;
    logic [0:35] iob_read = '0;
    logic [1:7]  pi_req = '0;
    logic [2:0]  pi_level;
    logic        pi_any;

    iobus_iot_sequencer #(
        .CLR_CYC(CLR_CYC), .GAP_CYC(GAP_CYC), .SET_CYC(SET_CYC),
        .RD_CYC(RD_CYC), .RST_CYC(RST_CYC)
    ) dut (
        .clk(clk), .reset(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dev(cmd_dev), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .io_reset_req(io_reset_req), .iob_poweron(iob_poweron), .iob_reset(iob_reset),
        .datao_clear(datao_clear), .datao_set(datao_set),
        .cono_clear(cono_clear), .cono_set(cono_set),
        .iob_fm_datai(iob_fm_datai), .iob_fm_status(iob_fm_status),
        .ios(ios), .iob_write(iob_write), .iob_read(iob_read),
        .pi_req(pi_req), .pi_level(pi_level), .pi_any(pi_any)
    );

    always #5 clk = ~clk;

    typedef struct { logic [35:0] data; int at; } exp_t;
    exp_t        sbq[$];
    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          cur_acc = -1000, last_acc = 0;
    logic [1:0]  cur_op = '0;
    logic [6:0]  cur_dev = '0;
    logic [35:0] cur_data = '0;
    logic [35:0] last_rsp = '0;
    logic [1:7]  pi_s = '0;
    logic        rst_s = 1'b0;
    logic [92:0] all_out;

    assign all_out = {iob_poweron, iob_reset, cmd_ready, rsp_valid, rsp_data, pi_level, pi_any,
                      datao_clear, datao_set, cono_clear, cono_set, iob_fm_datai, iob_fm_status,
                      ios, iob_write};

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pi_s  <= pi_req;
        rst_s <= rst_n;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [35:0] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    function automatic int pi_model(logic [1:7] r);
        for (int i = 1; i <= 7; i++)
            if (r[i]) return i;
        return 0;
    endfunction

    // Expected strobes/ios/iob_write from the offset into the current command.
    always @(negedge clk) begin
        int         n;
        logic [5:0] es;
        logic [6:0] eios;
        logic [35:0] ew;
        logic       clr, set, rd;
        n = cyc - cur_acc;
        es = '0; eios = '0; ew = '0;
        clr = (n <= CLR_CYC);
        set = (n >= CLR_CYC + GAP_CYC + 1) && (n <= CLR_CYC + GAP_CYC + SET_CYC);
        rd  = (n <= RD_CYC);
        if (rst_n && n >= 1) begin
            if (!cur_op[1] && n <= LEN_W) begin
                eios = cur_dev;
                ew   = cur_data;
                if (cur_op == 2'd0) es[5:4] = {clr, set};
                else                es[3:2] = {clr, set};
            end else if (cur_op[1] && n <= LEN_R) begin
                eios = cur_dev;
                es[1:0] = cur_op[0] ? {1'b0, rd} : {rd, 1'b0};
            end
        end
        check("bus", {datao_clear, datao_set, cono_clear, cono_set, iob_fm_datai, iob_fm_status,
                      ios, iob_write}, {es, eios, ew});
    end

    // Response monitor.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) last_rsp = '0;
        else if (rsp_valid) begin
            if (sbq.size() == 0) check("unexpected_rsp", rsp_valid, 1'b0);
            else begin
                e = sbq.pop_front();
                check("rsp_cycle", cyc, e.at);
                check("rsp_data", rsp_data, e.data);
                last_rsp = e.data;
            end
        end else check("rsp_hold", rsp_data, last_rsp);
    end

    // PI request driver and checker.
    initial forever begin
        @(negedge clk);
        check("pi", {pi_any, pi_level},
              (rst_n && rst_s) ? {pi_s != 0, 3'(pi_model(pi_s))} : 4'b0);
        case ($urandom_range(3))
            0: pi_req = 7'b0010100;
            1: pi_req = '0;
            default: pi_req = 7'($urandom()) & 7'($urandom());
        endcase
    end

    task automatic power_on();
        int n;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_out, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("poweron", iob_poweron, 1'b1);
        n = 0;
        while (iob_reset && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("reset_pulse_len", n, RST_CYC);
        #1 check("ready_after_reset", cmd_ready, 1'b1);
    endtask

    task automatic send(input logic [1:0] op, input logic [6:0] dev, input logic [35:0] data,
                        input logic [35:0] rdv, input int irq_off, input int abort_off,
                        input bit irq_offer);
        int w, len;
        len = op[1] ? LEN_R : LEN_W;
        @(negedge clk);
        cmd_op = op; cmd_dev = dev; cmd_data = data; cmd_valid = 1'b1; iob_read = rdv;
        if (irq_offer) begin
            io_reset_req = 1'b1;
            #1 check("ready_vs_io_reset", cmd_ready, 1'b0);
            @(negedge clk);
            io_reset_req = 1'b0;
        end
        w = 0;
        #1;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            #1 w++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        if (irq_offer) check("held_cmd_wait", w, RST_CYC + 1);
        cur_op = op; cur_dev = dev; cur_data = data; cur_acc = cyc; last_acc = cyc;
        sbq.push_back('{data: op[1] ? rdv : 36'd0, at: cyc + len});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom()); cmd_dev = 7'($urandom()); cmd_data = rnd36();
        for (int n = 1; n <= len; n++) begin
            @(negedge clk);
            if (op[1] && n == RD_CYC + 1) iob_read = rnd36();
            if (irq_off != 0 && n == irq_off) io_reset_req = 1'b1;
            else if (irq_off != 0 && n == irq_off + 1) io_reset_req = 1'b0;
            if (abort_off != 0 && n == abort_off) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                cur_acc = -1000;
                sbq.delete();
                #1 check("abort_outputs", all_out, '0);
                return;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        int         irq;
        power_on();
        send(2'd1, 7'o014, 36'o000000000777, 36'd0, 0, 0, 0);
        send(2'd2, 7'o070, rnd36(), 36'o123456765432, 0, 0, 0);
        send(2'd0, 7'o025, 36'o707070707070, 36'd0, 5, 0, 0);
        for (int k = LEN_W + 1; k <= LEN_W + RST_CYC + 2; k++) begin
            int n;
            @(negedge clk);
            #1 n = cyc - last_acc;
            check("io_reset_after_cmd", {cmd_ready, iob_reset},
                  {n == LEN_W + RST_CYC + 2, (n >= LEN_W + 2) && (n <= LEN_W + RST_CYC + 1)});
        end
        send(2'd3, 7'o104, rnd36(), rnd36(), 0, 0, 1);
        repeat (25) begin
            op  = 2'($urandom_range(3));
            irq = ($urandom_range(3) == 0) ? $urandom_range(1, (op[1] ? LEN_R : LEN_W) - 1) : 0;
            send(op, 7'($urandom()), rnd36(), rnd36(), irq, 0, 0);
        end
        send(2'd1, 7'o014, 36'o000000000777, 36'd0, 0, 7, 0);
        power_on();
        send(2'd2, 7'o070, rnd36(), rnd36(), 0, 0, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
